// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one single-beat AXI4 read master between the instruction fetch port (F)
// and the data load port (L). Round-robin grant, one transaction in flight at a
// time, and an in-flight fetch response can be discarded by a flush.

module axi_read_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // fetch requester
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic              f_valid,
   output logic [DATA_W-1:0] f_data,
   output logic              f_err,
   input  logic              f_flush,
   // load requester
   input  logic              l_req,
   input  logic [ADDR_W-1:0] l_addr,
   output logic              l_ack,
   output logic              l_valid,
   output logic [DATA_W-1:0] l_data,
   output logic              l_err,
   // AXI AR channel
   output logic [ADDR_W-1:0] araddr,
   output logic [3:0]        arid,
   output logic              arvalid,
   input  logic              arready,
   // AXI R channel
   input  logic [DATA_W-1:0] rdata,
   input  logic [3:0]        rid,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [3:0]          arid_q, arid_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic                f_ack_q, f_ack_d;
   logic                l_ack_q, l_ack_d;
   logic                f_valid_q, f_valid_d;
   logic                l_valid_q, l_valid_d;
   logic [DATA_W-1:0]   f_data_q, f_data_d;
   logic [DATA_W-1:0]   l_data_q, l_data_d;
   logic                f_err_q, f_err_d;
   logic                l_err_q, l_err_d;
   // grant encoding: 0 = fetch, 1 = load
   logic                gnt_q, gnt_d;
   logic                last_q, last_d;
   logic                drop_q, drop_d;

   logic                gnt_new;
   logic                flush_now;
   logic                resp_err;

   // Only the SLVERR/DECERR bit of the response matters here.
   logic                unused_rresp;
   assign unused_rresp = rresp[0];

   // Next-state and registered-output computation for the IDLE/ADDR/DATA sequence.
   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arid_d    = arid_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      f_ack_d   = 1'b0;
      l_ack_d   = 1'b0;
      f_valid_d = 1'b0;
      l_valid_d = 1'b0;
      f_data_d  = f_data_q;
      l_data_d  = l_data_q;
      f_err_d   = f_err_q;
      l_err_d   = l_err_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      drop_d    = drop_q;

      gnt_new   = (f_req && l_req) ? ~last_q : l_req;
      flush_now = f_flush && !gnt_q && (state_q != IDLE);
      resp_err  = rresp[1] || (rid != arid_q);

      if (flush_now) begin
         drop_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (f_req || l_req) begin
               araddr_d  = gnt_new ? l_addr : f_addr;
               arid_d    = {3'b000, gnt_new};
               arvalid_d = 1'b1;
               f_ack_d   = !gnt_new;
               l_ack_d   = gnt_new;
               gnt_d     = gnt_new;
               drop_d    = 1'b0;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (rvalid && rready_q) begin
               rready_d = 1'b0;
               last_d   = gnt_q;
               state_d  = IDLE;
               // A flush on the handshake cycle itself still suppresses the response.
               if (!drop_q && !flush_now) begin
                  if (gnt_q) begin
                     l_data_d  = rdata;
                     l_err_d   = resp_err;
                     l_valid_d = 1'b1;
                  end else begin
                     f_data_d  = rdata;
                     f_err_d   = resp_err;
                     f_valid_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         araddr_q  <= '0;
         arid_q    <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         f_ack_q   <= 1'b0;
         l_ack_q   <= 1'b0;
         f_valid_q <= 1'b0;
         l_valid_q <= 1'b0;
         f_data_q  <= '0;
         l_data_q  <= '0;
         f_err_q   <= 1'b0;
         l_err_q   <= 1'b0;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arid_q    <= arid_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         f_ack_q   <= f_ack_d;
         l_ack_q   <= l_ack_d;
         f_valid_q <= f_valid_d;
         l_valid_q <= l_valid_d;
         f_data_q  <= f_data_d;
         l_data_q  <= l_data_d;
         f_err_q   <= f_err_d;
         l_err_q   <= l_err_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         drop_q    <= drop_d;
      end
   end

   assign araddr  = araddr_q;
   assign arid    = arid_q;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;
   assign f_ack   = f_ack_q;
   assign l_ack   = l_ack_q;
   assign f_valid = f_valid_q;
   assign l_valid = l_valid_q;
   assign f_data  = f_data_q;
   assign l_data  = l_data_q;
   assign f_err   = f_err_q;
   assign l_err   = l_err_q;

endmodule
